a2d_seq: RTL and testbench

Round-robin conversion sequencer for the external 12-bit A2D converter that supplies the left load cell, right load cell and battery readings to the digital core. Each `nxt` strobe from the digital core starts one channel conversion. The block drives an SPI-master handshake through the two-transaction command/read protocol. It holds the latest result of each channel in registers that feed the core's `lft_ld`, `rght_ld` and `batt` inputs, and it enforces a timeout on the SPI master.

---
 rtl/a2d_seq.sv | 133 +++++++++++++
 tb/tb_a2d_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/a2d_seq.sv
// Round-robin A2D conversion sequencer: left -> right -> batt, two SPI transactions per channel.
// Define A2D_AVG_EN to average each new sample into its result register instead of overwriting it.
module a2d_seq #(
    parameter logic [2:0] LLD_CH  = 3'd0,
    parameter logic [2:0] RLD_CH  = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5,
    parameter int         TO_CYC  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, RD, WAIT2, STORE} state_t;
    typedef enum logic [1:0] {P_LFT, P_RGHT, P_BATT} ptr_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    state_t      state, nxt_state;
    ptr_t        ptr, ptr_nxt;
    logic        pend;
    logic [15:0] to_cnt;
    logic [2:0]  ch;
    logic        timeout, capture;
    logic        rd_unused;

    assign rd_unused = ^spi_rd[15:12];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        spi_wrt   = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE:  if (nxt || pend) nxt_state = CMD;
            CMD:   begin spi_wrt = 1'b1; nxt_state = WAIT1; end
            WAIT1: begin
                // done wins over a timeout landing in the same cycle
                if (spi_done) nxt_state = GAP;
                else if (to_cnt == TO_LAST) begin timeout = 1'b1; nxt_state = IDLE; end
            end
            GAP:   nxt_state = RD;
            RD:    begin spi_wrt = 1'b1; nxt_state = WAIT2; end
            WAIT2: begin
                if (spi_done) begin capture = 1'b1; nxt_state = STORE; end
                else if (to_cnt == TO_LAST) begin timeout = 1'b1; nxt_state = IDLE; end
            end
            STORE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cnv_cmplt = (state == STORE);

    always_comb begin
        case (ptr)
            P_LFT:   begin ch = LLD_CH;  ptr_nxt = P_RGHT; end
            P_RGHT:  begin ch = RLD_CH;  ptr_nxt = P_BATT; end
            default: begin ch = BATT_CH; ptr_nxt = P_LFT;  end
        endcase
    end

`ifdef A2D_AVG_EN
    logic [2:0] vld;

    function automatic logic [11:0] avg(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b} + 13'd1;
        return s[12:1];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= P_LFT;
            pend    <= 1'b0;
            to_cnt  <= 16'd0;
            spi_cmd <= 16'd0;
            err     <= 1'b0;
            lft_ld  <= 12'd0;
            rght_ld <= 12'd0;
            batt    <= 12'd0;
`ifdef A2D_AVG_EN
            vld     <= 3'b000;
`endif
        end else begin
            if (state == IDLE) pend <= 1'b0;
            else if (nxt)      pend <= 1'b1;

            if (state == CMD || state == RD)        to_cnt <= 16'd0;
            else if (state == WAIT1 || state == WAIT2) to_cnt <= to_cnt + 16'd1;

            if (state == IDLE && nxt_state == CMD) spi_cmd <= {2'b00, ch, 11'h000};

            if (timeout) err <= 1'b1;
            if (timeout || state == STORE) ptr <= ptr_nxt;

            // result written as STORE is entered so it is visible alongside cnv_cmplt
            if (capture) begin
`ifdef A2D_AVG_EN
                case (ptr)
                    P_LFT:   begin lft_ld  <= vld[0] ? avg(lft_ld,  spi_rd[11:0]) : spi_rd[11:0]; vld[0] <= 1'b1; end
                    P_RGHT:  begin rght_ld <= vld[1] ? avg(rght_ld, spi_rd[11:0]) : spi_rd[11:0]; vld[1] <= 1'b1; end
                    default: begin batt    <= vld[2] ? avg(batt,    spi_rd[11:0]) : spi_rd[11:0]; vld[2] <= 1'b1; end
                endcase
`else
                case (ptr)
                    P_LFT:   lft_ld  <= spi_rd[11:0];
                    P_RGHT:  rght_ld <= spi_rd[11:0];
                    default: batt    <= spi_rd[11:0];
                endcase
`endif
            end
        end
    end

endmodule

// File: tb/tb_a2d_seq.sv
// Directed bench for a2d_seq with an inline SPI responder; built with TO_CYC=8.
module tb_a2d_seq;

    logic        clk = 1'b0;
    logic        rst, nxt, spi_done;
    logic [15:0] spi_rd;
    logic        spi_wrt, cnv_cmplt, busy, err;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, batt;

    int checks = 0;
    int errors = 0;

`ifdef A2D_AVG_EN
    localparam logic [11:0] EXP_WRAP = 12'h2AB;
    localparam logic [11:0] EXP_BATT2 = 12'h181;
`else
    localparam logic [11:0] EXP_WRAP = 12'h444;
    localparam logic [11:0] EXP_BATT2 = 12'h201;
`endif

    always #5 clk = ~clk;

    a2d_seq #(.TO_CYC(8)) dut (
        .clk(clk), .rst(rst), .nxt(nxt),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rd(spi_rd),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .cnv_cmplt(cnv_cmplt), .busy(busy), .err(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst;
        rst = 1'b1; nxt = 1'b0; spi_done = 1'b0; spi_rd = 16'h0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] sel_reg(input int sel);
        return (sel == 0) ? lft_ld : (sel == 1) ? rght_ld : batt;
    endfunction

    // One full conversion; returns in the STORE cycle.
    task automatic conv(input bit kick, input int extra, input int exp_lat, input logic [15:0] exp_cmd,
                        input logic [15:0] rd, input int sel, input logic [11:0] exp_val, input string nm);
        int n;
        if (kick) begin nxt = 1'b1; step(); nxt = 1'b0; end
        n = 0;
        while (spi_wrt !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (n != exp_lat) begin errors++; $display("FAIL %s wrt1_lat got %0d exp %0d", nm, n, exp_lat); end
        checks++;
        if (spi_cmd !== exp_cmd) begin errors++; $display("FAIL %s cmd1 got %h exp %h", nm, spi_cmd, exp_cmd); end
        step();
        for (int i = 0; i < extra; i++) begin nxt = 1'b1; step(); nxt = 1'b0; step(); end
        spi_done = 1'b1; spi_rd = 16'hFFFF;
        step();
        spi_done = 1'b0;
        checks++;
        if ({spi_wrt, busy} !== 2'b01) begin errors++; $display("FAIL %s gap got wrt=%b busy=%b exp 0 1", nm, spi_wrt, busy); end
        step();
        checks++;
        if (spi_wrt !== 1'b1 || spi_cmd !== exp_cmd) begin
            errors++; $display("FAIL %s rd_wrt got wrt=%b cmd=%h exp 1 %h", nm, spi_wrt, spi_cmd, exp_cmd);
        end
        step();
        spi_done = 1'b1; spi_rd = rd;
        step();
        spi_done = 1'b0;
        checks++;
        if (cnv_cmplt !== 1'b1 || sel_reg(sel) !== exp_val) begin
            errors++; $display("FAIL %s store got cmplt=%b val=%h exp 1 %h", nm, cnv_cmplt, sel_reg(sel), exp_val);
        end
    endtask

    task automatic test_reset;
        do_rst();
        checks++;
        if ({spi_wrt, spi_cmd, lft_ld, rght_ld, batt, cnv_cmplt, busy, err} !== 55'd0) begin
            errors++; $display("FAIL reset outputs got wrt=%b cmd=%h l=%h r=%h b=%h c=%b busy=%b err=%b exp all 0",
                               spi_wrt, spi_cmd, lft_ld, rght_ld, batt, cnv_cmplt, busy, err);
        end
    endtask

    task automatic test_single;
        conv(1, 0, 0, 16'h0000, 16'h0ABC, 0, 12'hABC, "single");
        step();
        checks++;
        if ({cnv_cmplt, busy} !== 2'b00) begin errors++; $display("FAIL single idle got cmplt=%b busy=%b exp 0 0", cnv_cmplt, busy); end
        conv(1, 0, 0, 16'h2000, 16'h0321, 1, 12'h321, "single_ptr_right");
        step();
    endtask

    task automatic test_round_robin;
        do_rst();
        conv(1, 0, 0, 16'h0000, 16'h0111, 0, 12'h111, "rr_left");  step();
        conv(1, 0, 0, 16'h2000, 16'h0222, 1, 12'h222, "rr_right"); step();
        conv(1, 0, 0, 16'h2800, 16'h0333, 2, 12'h333, "rr_batt");  step();
        conv(1, 0, 0, 16'h0000, 16'h0444, 0, EXP_WRAP, "rr_wrap"); step();
    endtask

    task automatic test_back_to_back;
        int wrts;
        do_rst();
        conv(1, 2, 0, 16'h0000, 16'h00AA, 0, 12'h0AA, "b2b_first");
        conv(0, 0, 2, 16'h2000, 16'h00BB, 1, 12'h0BB, "b2b_second");
        wrts = 0;
        for (int i = 0; i < 10; i++) begin step(); if (spi_wrt === 1'b1) wrts++; end
        checks++;
        if (wrts != 0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got wrts=%0d busy=%b exp 0 0", wrts, busy); end
    endtask

    task automatic test_timeout;
        int seen;
        do_rst();
        conv(1, 0, 0, 16'h0000, 16'h05A5, 0, 12'h5A5, "to_pre_l"); step();
        conv(1, 0, 0, 16'h2000, 16'h00C3, 1, 12'h0C3, "to_pre_r"); step();
        conv(1, 0, 0, 16'h2800, 16'h03C3, 2, 12'h3C3, "to_pre_b"); step();
        nxt = 1'b1; step(); nxt = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 7; i++) begin step(); if (spi_wrt === 1'b1 || cnv_cmplt === 1'b1) seen++; end
        checks++;
        if ({busy, err} !== 2'b10 || seen != 0) begin
            errors++; $display("FAIL to_wait got busy=%b err=%b seen=%0d exp 1 0 0", busy, err, seen);
        end
        step();
        checks++;
        if ({busy, err, cnv_cmplt} !== 3'b010 || lft_ld !== 12'h5A5) begin
            errors++; $display("FAIL to_expire got busy=%b err=%b cmplt=%b lft=%h exp 0 1 0 5a5", busy, err, cnv_cmplt, lft_ld);
        end
        conv(1, 0, 0, 16'h2000, 16'h00C3, 1, 12'h0C3, "to_ptr_right");
        step();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got err=%b exp 1", err); end
        do_rst();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_clear got err=%b exp 0", err); end
    endtask

    task automatic test_timeout_edge;
        do_rst();
        nxt = 1'b1; step(); nxt = 1'b0;
        step();
        for (int i = 0; i < 7; i++) step();
        spi_done = 1'b1; spi_rd = 16'h0000;
        step();
        spi_done = 1'b0;
        checks++;
        if ({spi_wrt, busy, err} !== 3'b010) begin
            errors++; $display("FAIL edge_done_wins got wrt=%b busy=%b err=%b exp 0 1 0", spi_wrt, busy, err);
        end
        step();
        step();
        spi_done = 1'b1; spi_rd = 16'h0777;
        step();
        spi_done = 1'b0;
        checks++;
        if (cnv_cmplt !== 1'b1 || lft_ld !== 12'h777 || err !== 1'b0) begin
            errors++; $display("FAIL edge_store got cmplt=%b lft=%h err=%b exp 1 777 0", cnv_cmplt, lft_ld, err);
        end
        step();
    endtask

    task automatic test_reset_mid;
        do_rst();
        nxt = 1'b1; step(); nxt = 1'b0;
        step();
        spi_done = 1'b1; step(); spi_done = 1'b0;
        step();
        step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({spi_wrt, spi_cmd, lft_ld, rght_ld, batt, cnv_cmplt, busy, err} !== 55'd0) begin
            errors++; $display("FAIL rstmid outputs got wrt=%b cmd=%h l=%h c=%b busy=%b exp all 0", spi_wrt, spi_cmd, lft_ld, cnv_cmplt, busy);
        end
        spi_done = 1'b1; spi_rd = 16'h0FFF;
        step();
        spi_done = 1'b0;
        step();
        checks++;
        if ({spi_wrt, cnv_cmplt, busy} !== 3'b000 || lft_ld !== 12'h000) begin
            errors++; $display("FAIL rstmid_stray got wrt=%b c=%b busy=%b lft=%h exp 0 0 0 000", spi_wrt, cnv_cmplt, busy, lft_ld);
        end
    endtask

    task automatic test_batt_update;
        do_rst();
        conv(1, 0, 0, 16'h0000, 16'h0001, 0, 12'h001, "bu_l1"); step();
        conv(1, 0, 0, 16'h2000, 16'h0002, 1, 12'h002, "bu_r1"); step();
        conv(1, 0, 0, 16'h2800, 16'h0100, 2, 12'h100, "bu_b1"); step();
        conv(1, 0, 0, 16'h0000, 16'h0001, 0, 12'h001, "bu_l2"); step();
        conv(1, 0, 0, 16'h2000, 16'h0002, 1, 12'h002, "bu_r2"); step();
        conv(1, 0, 0, 16'h2800, 16'h0201, 2, EXP_BATT2, "bu_b2"); step();
    endtask

    initial begin
        rst = 1'b1; nxt = 1'b0; spi_done = 1'b0; spi_rd = 16'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_batt_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
